// File: rtl/nf10_arb_pkg.sv
// Shared definitions for the N-port input arbiter.
//   arb_state_t      : arbiter FSM encoding (ST_IDLE, ST_PKT)
//   ARB_MODE_RR/PRIO : values accepted by the C_ARB_MODE parameter
//   rotate_first_set : index of the first set request at or after a start
//                      position, searching upward and wrapping at num
package nf10_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_t;

  localparam int ARB_MODE_RR   = 0;
  localparam int ARB_MODE_PRIO = 1;
  localparam int MAX_PORTS     = 16;

  // Only the first num positions take part in the search. Because start < num
  // and k < num, start + k stays below 2*num, so a single subtraction wraps.
  function automatic logic [3:0] rotate_first_set(
    input logic [MAX_PORTS-1:0] req,
    input logic [3:0]           start,
    input int                   num
  );
    logic [3:0] idx;
    logic       found;
    int         p;
    idx   = 4'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      p = int'(start) + k;
      if (p >= num) begin
        p = p - num;
      end else begin
        p = p;
      end
      if ((k < num) && !found && req[p[3:0]]) begin
        idx   = p[3:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/nf10_axis_fifo2.sv
// Two-entry output buffer with registered outputs.
//   clk, reset : clock, synchronous active-high reset (empties the buffer)
//   wr_*       : write side; wr_ready is high whenever fewer than 2 entries
//   rd_*       : read side; rd_valid and rd_data come straight from registers
// The head register always holds the oldest entry, so rd_data needs no mux.
module nf10_axis_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] tail_nxt;
  logic             valid_q;
  logic             wr;
  logic             rd;

  assign wr_ready = (count != 2'd2);
  assign wr       = wr_valid & wr_ready;
  assign rd       = valid_q & rd_ready;
  assign rd_valid = valid_q;
  assign rd_data  = head;

  // Next occupancy and storage contents for each write/read combination
  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    tail_nxt  = tail;
    case (count)
      2'd0: begin
        if (wr) begin
          head_nxt  = wr_data;
          count_nxt = 2'd1;
        end else begin
          count_nxt = 2'd0;
        end
      end
      2'd1: begin
        if (wr && rd) begin
          head_nxt = wr_data;
        end else if (wr) begin
          tail_nxt  = wr_data;
          count_nxt = 2'd2;
        end else if (rd) begin
          count_nxt = 2'd0;
        end else begin
          count_nxt = 2'd1;
        end
      end
      2'd2: begin
        // wr cannot occur here since wr_ready is low when full
        if (rd) begin
          head_nxt  = tail;
          count_nxt = 2'd1;
        end else begin
          count_nxt = 2'd2;
        end
      end
      default: begin
        count_nxt = 2'd0;
      end
    endcase
  end

  // Storage and occupancy registers; valid is registered alongside count
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      head    <= '0;
      tail    <= '0;
      valid_q <= 1'b0;
    end else begin
      count   <= count_nxt;
      head    <= head_nxt;
      tail    <= tail_nxt;
      valid_q <= (count_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/nf10_input_arbiter_np.sv
// N-port AXI4-Stream input arbiter, packet granularity, round-robin or fixed
// priority (C_ARB_MODE), output registered through a 2-entry buffer.
//   axi_aclk, axi_reset : clock, synchronous active-high reset
//   s_axis_*            : C_NUM_PORTS flattened slave streams, port i at
//                         [i*W +: W] of each bus
//   m_axis_*            : merged master stream
// Optional (macro NF10_INPUT_ARBITER_PKT_CNT_EN):
//   pkt_cnt_clr         : synchronous clear of all packet counters
//   pkt_cnt             : per-port 32-bit count of accepted tlast beats,
//                         port i at [i*32 +: 32]
module nf10_input_arbiter_np
  import nf10_arb_pkg::*;
#(
  parameter int C_NUM_PORTS   = 5,
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 128,
  parameter int C_ARB_MODE    = 0
) (
  input  logic                                  axi_aclk,
  input  logic                                  axi_reset,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]             m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast
`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
  ,
  input  logic                                  pkt_cnt_clr,
  output logic [C_NUM_PORTS*32-1:0]             pkt_cnt
`endif
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int PAY_W  = C_DATA_WIDTH + STRB_W + C_TUSER_WIDTH + 1;

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [3:0]           grant;
  logic [3:0]           grant_nxt;
  logic [3:0]           rr_ptr;
  logic [3:0]           rr_ptr_nxt;
  logic [3:0]           search_start;
  logic [3:0]           winner;
  logic [MAX_PORTS-1:0] valid_pad;
  logic [MAX_PORTS-1:0] last_pad;
  logic [MAX_PORTS-1:0] ready_pad;
  logic                 fifo_in_ready;
  logic                 grant_ready;
  logic                 accept;
  logic                 accept_last;
  logic [PAY_W-1:0]     in_payload;
  logic [PAY_W-1:0]     out_payload;
  int                   gidx;

  // Pad per-port vectors to 16 bits so a 4-bit grant can index them directly
  assign valid_pad    = MAX_PORTS'(s_axis_tvalid);
  assign last_pad     = MAX_PORTS'(s_axis_tlast);
  assign search_start = (C_ARB_MODE == ARB_MODE_PRIO) ? 4'd0 : rr_ptr;
  assign winner       = rotate_first_set(valid_pad, search_start, C_NUM_PORTS);
  assign gidx         = int'(grant);

  // Reset gates tready so no beat is taken while the buffer is being flushed
  assign grant_ready = (state == ST_PKT) & fifo_in_ready & ~axi_reset;
  assign accept      = grant_ready & valid_pad[grant];
  assign accept_last = accept & last_pad[grant];

  // Only the granted port ever sees tready
  always_comb begin
    ready_pad        = '0;
    ready_pad[grant] = grant_ready;
  end

  assign s_axis_tready = ready_pad[C_NUM_PORTS-1:0];

  // Arbiter next-state: pick a winner in IDLE, hold the grant until tlast
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (|s_axis_tvalid) begin
          state_nxt = ST_PKT;
          grant_nxt = winner;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PKT: begin
        if (accept_last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (grant == 4'(C_NUM_PORTS - 1)) ? 4'd0 : grant + 4'd1;
        end else begin
          state_nxt = ST_PKT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbiter state, grant and round-robin pointer registers
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state  <= ST_IDLE;
      grant  <= 4'd0;
      rr_ptr <= 4'd0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  assign in_payload = {s_axis_tdata[gidx*C_DATA_WIDTH +: C_DATA_WIDTH],
                       s_axis_tstrb[gidx*STRB_W +: STRB_W],
                       s_axis_tuser[gidx*C_TUSER_WIDTH +: C_TUSER_WIDTH],
                       last_pad[grant]};

  nf10_axis_fifo2 #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk      (axi_aclk),
    .reset    (axi_reset),
    .wr_valid (accept),
    .wr_data  (in_payload),
    .wr_ready (fifo_in_ready),
    .rd_valid (m_axis_tvalid),
    .rd_ready (m_axis_tready),
    .rd_data  (out_payload)
  );

  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = out_payload;

`ifdef NF10_INPUT_ARBITER_PKT_CNT_EN
  for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_cnt
    logic [31:0] cnt;

    // Per-port packet counter; clear takes precedence over increment
    always_ff @(posedge axi_aclk) begin
      if (axi_reset || pkt_cnt_clr) begin
        cnt <= 32'd0;
      end else if (accept_last && (grant == 4'(i))) begin
        cnt <= cnt + 32'd1;
      end else begin
        cnt <= cnt;
      end
    end

    assign pkt_cnt[i*32 +: 32] = cnt;
  end
`endif

endmodule

// File: doc/nf10_input_arbiter_np.md
Name: nf10_input_arbiter_np

Overview:
- Parametrised N-port AXI4-Stream input arbiter. Next generation of the fixed five-port arbiter in the reference NIC datapath.
- Merges C_NUM_PORTS slave streams into one master stream at packet granularity. Supports selectable round-robin or fixed-priority mode.
- Output passes through a 2-entry buffer, so m_axis_* is registered.
- Sits between the per-port RX queues (10G MACs + DMA) and the output port lookup stage.

Parameters:
- C_NUM_PORTS, 5, number of slave input streams (2..16)
- C_DATA_WIDTH, 256, tdata width per stream; tstrb width = C_DATA_WIDTH/8
- C_TUSER_WIDTH, 128, tuser width per stream
- C_ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  synchronous active-high reset
- s_axis_tdata  in  C_NUM_PORTS*C_DATA_WIDTH  flattened; port i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
- s_axis_tstrb  in  C_NUM_PORTS*C_DATA_WIDTH/8  flattened, same scheme
- s_axis_tuser  in  C_NUM_PORTS*C_TUSER_WIDTH  flattened, same scheme
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid
- s_axis_tlast  in  C_NUM_PORTS  per-port last
- s_axis_tready  out  C_NUM_PORTS  per-port ready
- m_axis_tdata  out  C_DATA_WIDTH  merged data
- m_axis_tstrb  out  C_DATA_WIDTH/8  merged strobes
- m_axis_tuser  out  C_TUSER_WIDTH  merged tuser, passed unmodified
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  output last

Behaviour:
Clocking and reset:
- One clock, axi_aclk. axi_reset is synchronous and active-high.
- Reset values: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata/tstrb/tuser = 0.
- Internal state on reset: state = IDLE, grant = 0, rr_ptr = 0, buffer count = 0.

Arbiter FSM, IDLE -> PKT -> IDLE:
- IDLE: if any s_axis_tvalid is set, select a winner and register it into grant on the same edge; next state PKT.
  - Round-robin mode: winner is the first valid port at or after rr_ptr, searching upward and wrapping.
  - Fixed-priority mode: winner is the lowest-index valid port.
  - No valid input: stay in IDLE.
- PKT: s_axis_tready[grant] = (buffer count < 2). All other tready bits are 0.
- PKT: each accepted beat (tvalid & tready) is written to the buffer. An accepted beat with tlast set returns the FSM to IDLE and sets rr_ptr = grant+1, wrapping at C_NUM_PORTS.
- A packet is never interleaved with another port's beats.
- One idle cycle occurs between packets (arbitration cycle). Peak throughput is therefore 1 beat/cycle within a packet.
- In IDLE all s_axis_tready = 0.

Output buffer (2-entry FIFO, tdata/tstrb/tuser/tlast):
- Latency: 1 cycle from input handshake to m_axis_tvalid.
- m_axis_tvalid = (count != 0), driven from the head register.
- Simultaneous write and read: count unchanged, order preserved.
- Full (count = 2): tready to the granted port drops. No beat is lost or duplicated.
- Downstream backpressure can hold the buffer full indefinitely. The FSM stays in PKT.

Boundary conditions:
- Single-beat packet (tvalid & tlast on the first beat): PKT lasts one cycle; return to IDLE.
- Granted port drops tvalid mid-packet: grant is held and no other port is served.
- rr_ptr wraps from C_NUM_PORTS-1 to 0.
- Reset mid-packet: buffer contents are discarded, m_axis_tvalid drops on the next cycle, and the FSM returns to IDLE. Upstream is responsible for its partial packet.
- tuser is passed unmodified on every beat.

Optional Feature:
- Macro: NF10_INPUT_ARBITER_PKT_CNT_EN.
- When defined:
  - Adds input pkt_cnt_clr (1 bit) and output pkt_cnt (C_NUM_PORTS*32, port i at [i*32 +: 32]).
  - Counter i increments on each accepted tlast beat from port i and wraps from 2^32-1 to 0.
  - pkt_cnt_clr zeroes all counters synchronously. If a clear coincides with an increment, the clear wins.
  - Reset zeroes all counters.
- When undefined: these ports and counters do not exist. Datapath behaviour is identical.

Decomposition:
- Package nf10_arb_pkg holds:
  - the state encoding (ST_IDLE, ST_PKT);
  - mode constants ARB_MODE_RR = 0 and ARB_MODE_PRIO = 1;
  - a function computing the rotating first-set index.
- One sub-module: nf10_axis_fifo2, the 2-entry output buffer, parametrised on payload width.

Test Plan:
- Reset: hold axi_reset for 3 cycles with all tvalid high -> all s_axis_tready = 0 and m_axis_tvalid = 0 throughout; first grant goes to port 0.
- Round-robin: ports 0, 2 and 4 each continuously offer 3-beat packets, m_axis_tready = 1 -> output port order is 0, 2, 4, 0, ...; each packet is 3 contiguous beats followed by a 1-cycle gap.
- Fixed priority (C_ARB_MODE = 1): ports 1 and 3 offer packets continuously -> only port 1 packets appear; port 3 is served only when port 1 tvalid = 0 in IDLE.
- Backpressure: m_axis_tready toggles 1, 0, 0, 1 during an 8-beat packet -> all 8 beats are delivered in order, none duplicated; granted tready = 0 while count = 2.
- Single-beat packets from all 5 ports plus reset asserted mid-way through a 4-beat packet -> m_axis_tvalid = 0 the cycle after reset; the next grant comes from rr_ptr = 0.
- With NF10_INPUT_ARBITER_PKT_CNT_EN: 10 packets from port 2 -> pkt_cnt[95:64] = 10; pkt_cnt_clr asserted in the same cycle as an 11th tlast -> count = 0.
